// File: rtl/sudoku_group_sweeper_pkg.sv
// Shared Sudoku definitions: group size, digit mask width, sweeper states and one-hot helper.
package sudoku_pkg;
  localparam int DIGIT_W = 9;
  localparam int CELLS   = 9;
  localparam logic [DIGIT_W-1:0] ALL_DIGITS = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_LATCH,
    ST_DONE
  } sweep_state_e;

  function automatic logic is_onehot(input logic [DIGIT_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/sudoku_group_sweeper_if.sv
// Control handshake and shared cell bus between a group sweeper and its nine cells.
interface sudoku_group_sweeper_if #(
  parameter int CELLS   = 9,
  parameter int DIGIT_W = 9
) ();
  logic               start;
  logic               do_latch;
  logic               busy;
  logic               done;
  logic               conflict;
  logic [DIGIT_W-1:0] used_mask;
  logic               group_solved;
  logic [CELLS-1:0]   cell_oe;
  logic [CELLS-1:0]   cell_we;
  logic               address;
  logic               latch_singleton;
  logic [DIGIT_W-1:0] bus_i;
  logic [DIGIT_W-1:0] bus_o;
  logic               bus_drive;

  modport master (
    input  start, do_latch, bus_i,
    output busy, done, conflict, used_mask, group_solved,
           cell_oe, cell_we, address, latch_singleton, bus_o, bus_drive
  );

  modport slave (
    output start, do_latch, bus_i,
    input  busy, done, conflict, used_mask, group_solved,
           cell_oe, cell_we, address, latch_singleton, bus_o, bus_drive
  );
endinterface

// File: rtl/sudoku_group_sweeper.sv
// Reads a group's nine cells, accumulates the used-digit mask, broadcasts eliminations.
// Optional SUDOKU_SWEEPER_CONFLICT_ABORT_EN: a conflicting group skips WRITE/LATCH.
module sudoku_group_sweeper
  import sudoku_pkg::*;
#(
  parameter int CELLS   = sudoku_pkg::CELLS,
  parameter int DIGIT_W = sudoku_pkg::DIGIT_W
) (
  input logic clk,
  input logic reset,
  sudoku_group_sweeper_if.master bus
);
`ifdef SUDOKU_SWEEPER_CONFLICT_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [DIGIT_W-1:0] FULL = {DIGIT_W{1'b1}};

  sweep_state_e       state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               latch_req_q;
  logic               busy_q, done_q, conflict_q, solved_q;
  logic [DIGIT_W-1:0] used_q, bus_o_q;
  logic [CELLS-1:0]   cell_oe_q, cell_we_q;
  logic               address_q, latch_q, bus_drive_q;
  logic [DIGIT_W-1:0] used_d;
  logic               conflict_d;

  // Unsolved cells read back as zero and leave the mask untouched.
  always_comb begin
    used_d     = used_q | bus.bus_i;
    conflict_d = conflict_q;
    if (bus.bus_i != '0)
      conflict_d = conflict_q | !is_onehot(bus.bus_i) | ((used_q & bus.bus_i) != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      latch_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      conflict_q  <= 1'b0;
      solved_q    <= 1'b0;
      used_q      <= '0;
      bus_o_q     <= '0;
      cell_oe_q   <= '0;
      cell_we_q   <= '0;
      address_q   <= 1'b0;
      latch_q     <= 1'b0;
      bus_drive_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q     <= ST_READ;
            idx_q       <= '0;
            used_q      <= '0;
            conflict_q  <= 1'b0;
            solved_q    <= 1'b0;
            latch_req_q <= bus.do_latch;
            busy_q      <= 1'b1;
            cell_oe_q   <= CELLS'(1);
            address_q   <= 1'b0;
          end
        end
        ST_READ: begin
          used_q     <= used_d;
          conflict_q <= conflict_d;
          if (idx_q == LAST_IDX) begin
            cell_oe_q <= '0;
            if (ABORT_EN && conflict_d) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              solved_q <= 1'b0;
            end else begin
              state_q     <= ST_WRITE;
              cell_we_q   <= '1;
              address_q   <= 1'b1;
              bus_drive_q <= 1'b1;
              bus_o_q     <= ~used_d & FULL;
            end
          end else begin
            idx_q     <= idx_q + 1'b1;
            cell_oe_q <= cell_oe_q << 1;
          end
        end
        ST_WRITE: begin
          cell_we_q   <= '0;
          address_q   <= 1'b0;
          bus_drive_q <= 1'b0;
          bus_o_q     <= '0;
          if (latch_req_q) begin
            state_q <= ST_LATCH;
            latch_q <= 1'b1;
          end else begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            solved_q <= (used_q == FULL) && !conflict_q;
          end
        end
        ST_LATCH: begin
          latch_q  <= 1'b0;
          state_q  <= ST_DONE;
          done_q   <= 1'b1;
          solved_q <= (used_q == FULL) && !conflict_q;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.conflict        = conflict_q;
  assign bus.used_mask       = used_q;
  assign bus.group_solved    = solved_q;
  assign bus.cell_oe         = cell_oe_q;
  assign bus.cell_we         = cell_we_q;
  assign bus.address         = address_q;
  assign bus.latch_singleton = latch_q;
  assign bus.bus_o           = bus_o_q;
  assign bus.bus_drive       = bus_drive_q;
endmodule
